// File: rtl/word_assembler_128.sv
// word_assembler_128: packs byte lanes MSB-first into double-buffered 128-bit words
module word_assembler_128 #(
  parameter int WORD_W = 128,
  parameter int LANE_W = 8,
  localparam int LANES = WORD_W / LANE_W,
  localparam int CNT_W = $clog2(LANES) + 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              abort_i,
  input  logic [LANE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CNT_W-1:0]  fill_count_o
);
  logic [WORD_W-1:0] asm_q, asm_d, out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, ov_q, ov_d, acc, xfer, clr;
  // accept/transfer decode from registered state; abort overrides a pending transfer
  always_comb begin
    acc = in_valid_i & ~pend_q & ~abort_i;
    xfer = pend_q & (~ov_q | out_ready_i) & ~abort_i;
    clr = abort_i | xfer;
    asm_d = clr ? '0 : acc ? asm_q | ({in_data_i, {(WORD_W-LANE_W){1'b0}}} >> (cnt_q * LANE_W)) : asm_q;
    cnt_d = clr ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
    pend_d = clr ? 1'b0 : pend_q | (acc & (cnt_q == CNT_W'(LANES - 1)));
    out_d = xfer ? asm_q : out_q;
    ov_d = xfer | (ov_q & ~out_ready_i);
  end
  // state registers, asynchronously cleared
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      asm_q <= '0;
      cnt_q <= '0;
      pend_q <= 1'b0;
      out_q <= '0;
      ov_q <= 1'b0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      out_q <= out_d;
      ov_q <= ov_d;
    end
  end
  assign in_ready_o = ~pend_q;
  assign out_data_o = out_q;
  assign out_valid_o = ov_q;
  assign fill_count_o = cnt_q;
endmodule
